// File: rtl/two_dim_dec_ram.sv
// two_dim_dec_ram: synchronous two-dimensional decoded RAM.
// The word address is split into {row, col}. The row decoder picks one row of
// 2^COL_BITS words and the column mux picks the word inside it. After reset, or
// after a clr pulse, a sequencer clears one whole row per cycle. While that runs,
// ready is low. Reads are registered and flagged by a one-cycle rd_valid pulse.
//
// Handshake: an access is taken at a rising edge only when ready=1 and mem_en=1,
// and clr=0 at the same edge. There is no back-pressure beyond ready. A read
// answers exactly one cycle later with rd_valid=1. rd_data then holds until the
// next read.
//
// Optional feature: define PARITY_EN to store an even-parity bit per word and
// flag a mismatch on par_err. When it is undefined, par_err is 0.
module two_dim_dec_ram #(
   parameter int DATA_W   = 4,
   parameter int ROW_BITS = 2,
   parameter int COL_BITS = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mem_en,
   input  logic                         rd_wr,
   input  logic [ROW_BITS+COL_BITS-1:0] addr,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         clr,
   input  logic                         par_inj,
   output logic                         ready,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_valid,
   output logic                         par_err
);

   localparam int ADDR_W = ROW_BITS + COL_BITS;
   localparam int ROWS   = 1 << ROW_BITS;
   localparam int COLS   = 1 << COL_BITS;
   localparam logic [ROW_BITS-1:0] ROW_LAST = '1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ROW_BITS-1:0] row_cnt_q, row_cnt_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                par_err_q, par_err_d;

   // Storage array: indexed [row][col]; contents are never reset directly.
   logic [DATA_W-1:0]   mem_q [ROWS][COLS];

   logic [ROW_BITS-1:0] row_sel;
   logic [COL_BITS-1:0] col_sel;
   logic                access;
   logic                row_clr_we;
   logic                word_we;
   logic [DATA_W-1:0]   rd_word;
   logic                rd_par_bad;

   assign row_sel = addr[ADDR_W-1:COL_BITS];
   assign col_sel = addr[COL_BITS-1:0];
   assign rd_word = mem_q[row_sel][col_sel];

   // clr wins over a same-edge access, so the access is dropped.
   assign access  = (state_q == ST_IDLE) && mem_en && !clr;

`ifdef PARITY_EN
   logic par_q [ROWS][COLS];

   // Stored parity bit is read alongside the data word.
   assign rd_par_bad = ((^rd_word) != par_q[row_sel][col_sel]);

   // Parity array follows the data array: cleared by rows, written by words.
   always_ff @(posedge clk) begin
      if (row_clr_we) begin
         par_q[row_cnt_q] <= '{default: 1'b0};
      end
      if (word_we) begin
         par_q[row_sel][col_sel] <= (^wr_data) ^ par_inj;
      end
   end
`else
   logic unused_par_inj;

   assign unused_par_inj = par_inj;
   assign rd_par_bad     = 1'b0;
`endif

   // Sequencer next state, array write strobes and the registered read path.
   always_comb begin
      state_d    = state_q;
      row_cnt_d  = row_cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      par_err_d  = par_err_q;
      row_clr_we = 1'b0;
      word_we    = 1'b0;

      case (state_q)
         ST_INIT: begin
            row_clr_we = 1'b1;
            row_cnt_d  = row_cnt_q + 1'b1;
            if (row_cnt_q == ROW_LAST) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (access) begin
               if (rd_wr) begin
                  rd_data_d  = rd_word;
                  rd_valid_d = 1'b1;
                  par_err_d  = rd_par_bad;
               end else begin
                  word_we = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      if (clr) begin
         state_d   = ST_INIT;
         row_cnt_d = '0;
      end
   end

   // Control and read-port registers, asynchronously reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         row_cnt_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         par_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         par_err_q  <= par_err_d;
      end
   end

   // Data array: whole-row clear during INIT, single-word write in IDLE.
   always_ff @(posedge clk) begin
      if (row_clr_we) begin
         mem_q[row_cnt_q] <= '{default: '0};
      end
      if (word_we) begin
         mem_q[row_sel][col_sel] <= wr_data;
      end
   end

   assign ready    = (state_q == ST_IDLE);
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign par_err  = par_err_q;

endmodule

// File: tb/tb_two_dim_dec_ram.sv
// Bench for two_dim_dec_ram (DATA_W=4, ROW_BITS=2, COL_BITS=1).
// It runs a hand-written vector table first, then an async-reset sequence, then
// randomized traffic checked against a word-array reference model.
module tb_two_dim_dec_ram;

   localparam int DATA_W   = 4;
   localparam int ROW_BITS = 2;
   localparam int COL_BITS = 1;
   localparam int DEPTH    = 8;
`ifdef PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic              mem_en  = 1'b0;
   logic              rd_wr   = 1'b0;
   logic [2:0]        addr    = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              clr     = 1'b0;
   logic              par_inj = 1'b0;
   logic              ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              par_err;

   int checks   = 0;
   int failures = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   two_dim_dec_ram #(
      .DATA_W  (DATA_W),
      .ROW_BITS(ROW_BITS),
      .COL_BITS(COL_BITS)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mem_en  (mem_en),
      .rd_wr   (rd_wr),
      .addr    (addr),
      .wr_data (wr_data),
      .clr     (clr),
      .par_inj (par_inj),
      .ready   (ready),
      .rd_data (rd_data),
      .rd_valid(rd_valid),
      .par_err (par_err)
   );

   // ---------------- vector table ----------------
   typedef struct packed {
      logic       en;
      logic       rw;
      logic [2:0] a;
      logic [3:0] wd;
      logic       c;
      logic       inj;
      logic       e_rdy;
      logic       e_vld;
      logic [3:0] e_dat;
      logic       e_perr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic en, input logic rw, input logic [2:0] a,
                      input logic [3:0] wd, input logic c, input logic inj,
                      input logic e_rdy, input logic e_vld, input logic [3:0] e_dat,
                      input logic e_perr);
      vec_t v;
      v.en = en; v.rw = rw; v.a = a; v.wd = wd; v.c = c; v.inj = inj;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat; v.e_perr = e_perr;
      vecs.push_back(v);
   endtask

   task automatic idle_vec(input logic e_rdy, input logic [3:0] e_dat, input logic e_perr);
      add(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, e_rdy, 1'b0, e_dat, e_perr);
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic en, input logic rw, input logic [2:0] a,
                        input logic [3:0] wd, input logic c, input logic inj);
      mem_en = en; rd_wr = rw; addr = a; wr_data = wd; clr = c; par_inj = inj;
   endtask

   // One clock: inputs are already driven; outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_rdy, input logic e_vld,
                             input logic [3:0] e_dat, input logic e_perr);
      check({tag, "_ready"},    {31'd0, ready},    {31'd0, e_rdy});
      check({tag, "_rd_valid"}, {31'd0, rd_valid}, {31'd0, e_vld});
      check({tag, "_rd_data"},  {28'd0, rd_data},  {28'd0, e_dat});
      check({tag, "_par_err"},  {31'd0, par_err},  {31'd0, e_perr});
   endtask

   // ---------------- reference model ----------------
   // Every word is either known data or zero. Clearing is modelled as
   // instantaneous; this is equivalent because no access is taken while
   // ready=0. A word's parity error flag is simply the par_inj used when
   // that word was written.
   logic [3:0] m_mem [DEPTH];
   logic       m_err [DEPTH];
   int         m_busy;
   logic [3:0] m_dat;
   logic       m_vld;
   logic       m_perr;

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = 4'h0;
         m_err[i] = 1'b0;
      end
      m_busy = 1 << ROW_BITS;
      m_vld  = 1'b0;
   endtask

   task automatic model_step(input logic en, input logic rw, input logic [2:0] a,
                             input logic [3:0] wd, input logic c, input logic inj);
      m_vld = 1'b0;
      if (c) begin
         model_clear();
      end else if (m_busy > 0) begin
         m_busy--;
      end else if (en) begin
         if (rw) begin
            m_dat  = m_mem[a];
            m_perr = m_err[a] & PAR;
            m_vld  = 1'b1;
         end else begin
            m_mem[a] = wd;
            m_err[a] = inj;
         end
      end
   endtask

   // ---------------- test ----------------
   initial begin
      // T1 / T2 / T3: after reset release.
      idle_vec(1'b0, 4'h0, 1'b0);
      idle_vec(1'b0, 4'h0, 1'b0);
      idle_vec(1'b0, 4'h0, 1'b0);
      idle_vec(1'b1, 4'h0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         add(1'b1, 1'b1, 3'(i), 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
      end
      add(1'b1, 1'b0, 3'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      add(1'b1, 1'b0, 3'd1, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      add(1'b1, 1'b0, 3'd6, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      add(1'b1, 1'b0, 3'd7, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      add(1'b1, 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
      add(1'b1, 1'b1, 3'd1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0);
      add(1'b1, 1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110, 1'b0);
      add(1'b1, 1'b1, 3'd7, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
      add(1'b1, 1'b0, 3'd3, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0);
      add(1'b1, 1'b1, 3'd3, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0);
      // T4: clr with a same-edge write; accesses during INIT are ignored.
      add(1'b1, 1'b0, 3'd5, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0);
      add(1'b1, 1'b1, 3'd3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0);
      add(1'b1, 1'b0, 3'd0, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0);
      idle_vec(1'b0, 4'b1010, 1'b0);
      idle_vec(1'b1, 4'b1010, 1'b0);
      add(1'b1, 1'b1, 3'd5, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
      add(1'b1, 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
      add(1'b1, 1'b1, 3'd1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
      add(1'b1, 1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
      add(1'b1, 1'b1, 3'd7, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
      add(1'b1, 1'b1, 3'd3, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
      // T6: parity injection, then par_err holding with rd_data.
      add(1'b1, 1'b0, 3'd2, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      add(1'b1, 1'b0, 3'd4, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      add(1'b1, 1'b1, 3'd4, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b0);
      add(1'b1, 1'b1, 3'd2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0111, PAR);
      idle_vec(1'b1, 4'b0111, PAR);
      // clr with a same-edge read: read dropped, outputs hold through INIT.
      add(1'b1, 1'b1, 3'd4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111, PAR);
      idle_vec(1'b0, 4'b0111, PAR);
      idle_vec(1'b0, 4'b0111, PAR);
      idle_vec(1'b0, 4'b0111, PAR);
      idle_vec(1'b1, 4'b0111, PAR);
      add(1'b1, 1'b1, 3'd2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);

      // Reset state, checked after a couple of edges with rst_n low.
      drive(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      tick();
      check_outs("reset", 1'b0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].rw, vecs[i].a, vecs[i].wd, vecs[i].c, vecs[i].inj);
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld,
                    vecs[i].e_dat, vecs[i].e_perr);
      end

      // T5: write 1111@7, read it, then drop rst_n mid-cycle.
      drive(1'b1, 1'b0, 3'd7, 4'b1111, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 3'd7, 4'h0, 1'b0, 1'b0);
      tick();
      check_outs("t5_read", 1'b1, 1'b1, 4'b1111, 1'b0);
      drive(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("t5_async_rst", 1'b0, 1'b0, 4'h0, 1'b0);

      // Randomized traffic against the reference model.
      tick();
      model_clear();
      m_dat  = 4'h0;
      m_perr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 600; n++) begin
         logic       en, rw, c, inj;
         logic [2:0] a;
         logic [3:0] wd;
         en  = ($urandom_range(0, 9) < 7);
         rw  = 1'($urandom_range(0, 1));
         a   = 3'($urandom_range(0, DEPTH - 1));
         wd  = 4'($urandom_range(0, 15));
         c   = ($urandom_range(0, 49) == 0);
         inj = ($urandom_range(0, 3) == 0);
         drive(en, rw, a, wd, c, inj);
         model_step(en, rw, a, wd, c, inj);
         tick();
         check_outs($sformatf("rnd%0d", n), (m_busy == 0), m_vld, m_dat, m_perr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
